// File: rtl/ascon_session_ctrl.sv
// ---------------------------------------------------------------------------
// ascon_session_ctrl
//
// Runs one complete ASCON encrypt or decrypt session on the bit-serial ascon
// core. A parallel request is accepted over valid/ready. The core is held in
// reset, and every operand is then streamed in MSB first. The controller
// issues the start strobe for the requested mode and waits for the core's
// done flag. It then deserialises the core's LSB-first text/tag results into
// a parallel response, which it returns over valid/ready.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   req_*               request handshake and operands (mode 0 enc, 1 dec)
//   rsp_*               response handshake, text, tag, auth flag, error flag
//   core_rst            synchronous active-high reset to the core
//   core_*_bit          serial operand bits into the core
//   core_en_start,
//   core_dec_start      start strobes, held until the matching ready flag
//   core_en_ready,
//   core_de_ready       core done flags (also qualify the output stream)
//   core_text_o,
//   core_tag_o,
//   core_auth           serial result bits and authentication flag
// ---------------------------------------------------------------------------
module ascon_session_ctrl #(
  parameter int KEY_l   = 128,
  parameter int A_l     = 40,
  parameter int TEXT_l  = 40,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mode,
  input  logic [KEY_l-1:0]  req_key,
  input  logic [127:0]      req_nonce,
  input  logic [A_l-1:0]    req_ad,
  input  logic [TEXT_l-1:0] req_text,
  input  logic [127:0]      req_tag,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TEXT_l-1:0] rsp_text,
  output logic [127:0]      rsp_tag,
  output logic              rsp_auth,
  output logic              rsp_err,

  output logic              core_rst,
  output logic              core_key_bit,
  output logic              core_nonce_bit,
  output logic              core_ad_bit,
  output logic              core_text_bit,
  output logic              core_tag_bit,
  output logic              core_en_start,
  output logic              core_dec_start,
  input  logic              core_en_ready,
  input  logic              core_de_ready,
  input  logic              core_text_o,
  input  logic              core_tag_o,
  input  logic              core_auth
);

  // Longest serial operand (LOAD runs MAXL+1 cycles) and longest result
  // (CAPT runs CAPL cycles).
  localparam int KT_MAX  = (KEY_l > TEXT_l) ? KEY_l : TEXT_l;
  localparam int A_MAX   = (A_l > 128) ? A_l : 128;
  localparam int MAXL    = (KT_MAX > A_MAX) ? KT_MAX : A_MAX;
  localparam int CAPL    = (TEXT_l > 128) ? TEXT_l : 128;

  // One counter serves as the LOAD bit index, the START wait counter and the
  // CAPT bit index, so it is sized for the largest of the three.
  localparam int CNT_LC  = (MAXL > CAPL) ? MAXL : CAPL;
  localparam int CNT_TOP = (CNT_LC > TIMEOUT) ? CNT_LC : TIMEOUT;
  localparam int CW      = $clog2(CNT_TOP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_LOAD,
    S_START,
    S_CAPT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mode_q, mode_d;

  // Operand registers double as MSB-first shift registers during LOAD. Once
  // an operand's own width has gone by, zeros shift into its MSB, so it reads
  // 0 for the remaining LOAD cycles without any per-operand compare.
  logic [KEY_l-1:0]  key_q, key_d;
  logic [127:0]      nonce_q, nonce_d;
  logic [A_l-1:0]    ad_q, ad_d;
  logic [TEXT_l-1:0] text_q, text_d;
  logic [127:0]      tag_q, tag_d;

  logic [TEXT_l-1:0] rsp_text_q, rsp_text_d;
  logic [127:0]      rsp_tag_q, rsp_tag_d;
  logic              rsp_auth_q, rsp_auth_d;
  logic              rsp_err_q, rsp_err_d;

  logic              core_ready;

  // The done flag that matters is the one for the mode in flight.
  assign core_ready = mode_q ? core_de_ready : core_en_ready;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    key_d      = key_q;
    nonce_d    = nonce_q;
    ad_d       = ad_q;
    text_d     = text_q;
    tag_d      = tag_q;
    rsp_text_d = rsp_text_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_auth_d = rsp_auth_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mode_d    = req_mode;
          key_d     = req_key;
          nonce_d   = req_nonce;
          ad_d      = req_ad;
          text_d    = req_text;
          tag_d     = req_tag;
          rsp_err_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_CRST;
        end
      end

      S_CRST: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end

      S_LOAD: begin
        key_d   = key_q << 1;
        nonce_d = nonce_q << 1;
        ad_d    = ad_q << 1;
        text_d  = text_q << 1;
        tag_d   = tag_q << 1;
        if (cnt_q == CW'(MAXL)) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_START: begin
        if (core_ready) begin
          cnt_d   = '0;
          state_d = S_CAPT;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_CAPT: begin
        if (!core_ready) begin
          // The core stopped streaming early, so the response is incomplete.
          rsp_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          // Results arrive LSB first. Shifting in at the top puts bit k at
          // index k once the full width has gone by.
          if (cnt_q < CW'(TEXT_l)) rsp_text_d = {core_text_o, rsp_text_q[TEXT_l-1:1]};
          if (cnt_q < CW'(128))    rsp_tag_d  = {core_tag_o, rsp_tag_q[127:1]};
          // The core's auth flag has meaning only for decrypt.
          if (cnt_q == '0)         rsp_auth_d = mode_q ? core_auth : 1'b1;
          if (cnt_q == CW'(CAPL - 1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the control state. A
  // mid-session reset must return rsp_* to zero immediately, and nothing
  // leftover from a session should sit on the outputs after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      key_q      <= '0;
      nonce_q    <= '0;
      ad_q       <= '0;
      text_q     <= '0;
      tag_q      <= '0;
      rsp_text_q <= '0;
      rsp_tag_q  <= '0;
      rsp_auth_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      // NOTE: state updates are non-blocking, so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      key_q      <= key_d;
      nonce_q    <= nonce_d;
      ad_q       <= ad_d;
      text_q     <= text_d;
      tag_q      <= tag_d;
      rsp_text_q <= rsp_text_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_auth_q <= rsp_auth_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Handshake and core controls decode straight from state. Asserting reset
  // therefore forces their idle values at once, without waiting for a clock.
  assign req_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_DONE);
  assign core_rst       = (state_q == S_IDLE) || (state_q == S_CRST);

  assign core_key_bit   = (state_q == S_LOAD) && key_q[KEY_l-1];
  assign core_nonce_bit = (state_q == S_LOAD) && nonce_q[127];
  assign core_ad_bit    = (state_q == S_LOAD) && ad_q[A_l-1];
  assign core_text_bit  = (state_q == S_LOAD) && text_q[TEXT_l-1];
  assign core_tag_bit   = (state_q == S_LOAD) && tag_q[127];

  assign core_en_start  = (state_q == S_START) && !mode_q;
  assign core_dec_start = (state_q == S_START) &&  mode_q;

  assign rsp_text       = rsp_text_q;
  assign rsp_tag        = rsp_tag_q;
  assign rsp_auth       = rsp_auth_q;
  assign rsp_err        = rsp_err_q;

endmodule

// File: doc/ascon_session_ctrl.md
Name: ascon_session_ctrl

Overview:
- Sequencer that runs one complete ASCON encrypt or decrypt session on the bit-serial ascon core.
- Accepts a parallel request (key, nonce, AD, text, tag) over a valid/ready handshake and pulses the core's reset.
- Streams all operands into the core serially, then issues en_start or dec_start.
- Deserialises the core's serial text/tag/auth outputs into a parallel response, also returned over valid/ready.
- Sits between the host/bus-side logic and the ascon instance; the core is used for one session at a time.

Parameters:
KEY_l, 128, key width in bits (must match core)
A_l, 40, associated-data width (must match core)
TEXT_l, 40, plaintext/ciphertext width (must match core)
TIMEOUT, 4096, max cycles in WAIT before abort with error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request (IDLE only)
req_mode  in  1  0 = encrypt, 1 = decrypt
req_key  in  KEY_l  key
req_nonce  in  128  nonce
req_ad  in  A_l  associated data
req_text  in  TEXT_l  plaintext (enc) or ciphertext (dec)
req_tag  in  128  expected tag (dec; ignored for enc)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_text  out  TEXT_l  ciphertext (enc) or plaintext (dec)
rsp_tag  out  128  computed tag
rsp_auth  out  1  decrypt authenticated (enc: 1)
rsp_err  out  1  session aborted by timeout or protocol error
core_rst  out  1  synchronous active-high reset to core
core_key_bit, core_nonce_bit, core_ad_bit, core_text_bit, core_tag_bit  out  1 each  serial operand bits
core_en_start, core_dec_start  out  1 each  start strobes
core_en_ready, core_de_ready  in  1 each  core done flags
core_text_o, core_tag_o  in  1 each  serial result bits (ciphertext_o/plaintext_o and tag_o/dectag_o, muxed externally or internally by mode)
core_auth  in  1  msg_auth from core

Behaviour:
- Reset (rst=0, async) values: state=IDLE; req_ready=1; rsp_valid=0; rsp_text=0; rsp_tag=0; rsp_auth=0; rsp_err=0; core_rst=1; all core serial bits and start strobes 0; all counters 0.
- MAXL = max(KEY_l, 128, A_l, TEXT_l); CAPL = max(TEXT_l, 128).
- IDLE:
  - req_ready=1; core_rst=1.
  - On req_valid&req_ready: latch all request fields and mode; go to CRST.
- CRST (1 cycle): core_rst=1; i=0; go to LOAD.
- LOAD (MAXL+1 cycles, i = 0..MAXL):
  - core_rst=0.
  - For each operand of width L: drive bit [L-1-i] while i<L, else 0 (MSB first). Nonce and tag use L=128.
  - After i=MAXL go to START.
- START:
  - Assert core_en_start (mode 0) or core_dec_start (mode 1); hold until the corresponding core_*_ready is sampled 1.
  - Then deassert the strobe, clear k, go to CAPT.
  - The START dwell is counted by the wait counter; reaching TIMEOUT sets rsp_err=1 and goes to DONE.
- CAPT (CAPL cycles):
  - Core output bit k is valid the cycle after ready; sample core_text_o into rsp_text[k] for k<TEXT_l and core_tag_o into rsp_tag[k] for k<128 (LSB first).
  - Sample core_auth at k=0 into rsp_auth (enc forces 1).
  - If the ready flag drops during CAPT: rsp_err=1, go to DONE immediately.
- DONE:
  - rsp_valid=1 and all rsp_* held stable.
  - On rsp_ready: rsp_valid=0, core_rst=1, go to IDLE.
  - req_ready stays 0 in every state other than IDLE.
- rsp_err is cleared when the next request is accepted. On decrypt with rsp_auth=0, rsp_text/rsp_tag hold whatever the core emitted (all 1s); no masking.
- Simultaneous req_valid in DONE is ignored until IDLE; the earliest next accept is the cycle after the DONE handshake.
- Latency, accept to rsp_valid: 1 (CRST) + MAXL+1 (LOAD) + core compute + CAPL + 1. With defaults: 130 + core + 129.
- Reset mid-session: outputs return to reset values immediately; core_rst=1 keeps the core cleared; no response is produced.

Test Plan:
- Encrypt, key=0x000102…0F, nonce=0x101112…1F, AD=0x0102030405, PT=0x4142434445 -> rsp_text/rsp_tag match the ASCON golden model; rsp_auth=1, rsp_err=0; LOAD lasts exactly 129 cycles.
- Decrypt using the ciphertext/tag from the previous test -> rsp_text=0x4142434445, rsp_auth=1, rsp_tag equals the encrypt tag.
- Decrypt with one flipped tag bit (bit 0) -> rsp_auth=0, rsp_text=all 1s (0xFFFFFFFFFF), rsp_err=0.
- Core model never raises ready, TIMEOUT=64 -> rsp_err=1 and rsp_valid exactly 64 cycles after START entry (±1 documented); strobe dropped.
- rsp_ready held 0 for 20 cycles with req_valid=1 -> rsp_* stable, req_ready=0; a second request is accepted only the cycle after the rsp handshake.
- Assert rst mid-LOAD (i=50) -> rsp_valid=0, req_ready=1, core_rst=1 asynchronously; a fresh encrypt afterwards produces the golden result.
